// File: rtl/seq_multiplier_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
//   state_e : controller states IDLE -> BUSY -> FIN -> DONE
//   abs_op  : magnitude of a w-bit operand, two's complement when is_signed=1
package seq_multiplier_pkg;

  // Widest operand abs_op can handle; callers zero-extend into this width.
  localparam int unsigned ABS_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } state_e;

  // |x| over the low w bits of x. A negative value is negated modulo 2^w, so the
  // most negative value maps onto itself, which is the correct unsigned magnitude.
  function automatic logic [ABS_MAX_W-1:0] abs_op(input logic [ABS_MAX_W-1:0] x,
                                                  input int unsigned          w,
                                                  input logic                 is_signed);
    logic [ABS_MAX_W-1:0] mask;
    logic [ABS_MAX_W-1:0] val;
    logic                 is_neg;
    mask   = (w >= ABS_MAX_W) ? '1 : ((ABS_MAX_W'(1) << w) - ABS_MAX_W'(1));
    val    = x & mask;
    is_neg = (w != 0) && (|(val & (ABS_MAX_W'(1) << (w - 1))));
    if (is_signed && is_neg) begin
      val = (~val + ABS_MAX_W'(1)) & mask;
    end
    return val;
  endfunction

endpackage

// File: rtl/mul_operand_abs.sv
// Operand conditioning for seq_multiplier: converts both operands to magnitudes
// and computes the sign of the product.
//   in_a, in_b : raw operands (WIDTH bits)
//   in_signed  : 1 = two's complement operands, 0 = unsigned
//   abs_a      : |in_a|
//   abs_b      : |in_b|
//   neg        : product must be negated; forced low when either operand is zero
module mul_operand_abs
  import seq_multiplier_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_signed,
  output logic [WIDTH-1:0] abs_a,
  output logic [WIDTH-1:0] abs_b,
  output logic             neg
);

  assign abs_a = WIDTH'(abs_op(ABS_MAX_W'(in_a), WIDTH, in_signed));
  assign abs_b = WIDTH'(abs_op(ABS_MAX_W'(in_b), WIDTH, in_signed));

  // A zero operand never yields a negative result, so there is no -0 to resolve.
  assign neg = in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]) & (|in_a) & (|in_b);

endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, one partial product
// per clock, signed or unsigned per operation, one operation in flight.
// Optional feature macro: SEQ_MULTIPLIER_EARLY_TERM_EN -- when defined, BUSY ends
// as soon as the remaining multiplier bits are all zero (minimum one step).
//   clk       : clock, rising edge
//   rst       : asynchronous, active-high reset
//   in_a      : multiplicand
//   in_b      : multiplier
//   in_signed : 1 = two's complement operands
//   in_vld    : operands valid
//   in_rdy    : block can accept operands (combinational)
//   res       : product, held while res_vld=1
//   res_vld   : product valid
//   res_rdy   : consumer accepts product
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic               in_vld,
  output logic               in_rdy,
  output logic [2*WIDTH-1:0] res,
  output logic               res_vld,
  input  logic               res_rdy
);

  localparam int unsigned PW = 2 * WIDTH;

  state_e           state;
  logic [PW-1:0]    mcand;
  logic [PW-1:0]    acc;
  logic [WIDTH-1:0] mplier;
  logic             neg;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic             op_neg;
  logic             accept;
  logic             last_step;
  logic [PW-1:0]    acc_step;

  mul_operand_abs #(
    .WIDTH (WIDTH)
  ) u_operand_abs (
    .in_a      (in_a),
    .in_b      (in_b),
    .in_signed (in_signed),
    .abs_a     (abs_a),
    .abs_b     (abs_b),
    .neg       (op_neg)
  );

  // Ready in IDLE, or in DONE when the result pops on this edge (no bubble).
  // Held low during reset.
  assign in_rdy = ~rst & ((state == IDLE) | ((state == DONE) & res_rdy));
  assign accept = in_vld & in_rdy;

  // One partial product per step.
  assign acc_step = mplier[0] ? (acc + mcand) : acc;

`ifdef SEQ_MULTIPLIER_EARLY_TERM_EN
  // Last step when no set bits remain above the one consumed now.
  assign last_step = (mplier[WIDTH-1:1] == '0);
`else
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0] cnt;

  // cnt counts completed steps; the step taken with cnt==WIDTH-1 is the last.
  assign last_step = (cnt == CNT_W'(WIDTH - 1));
`endif

  // Controller and datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      mcand   <= '0;
      acc     <= '0;
      mplier  <= '0;
      neg     <= 1'b0;
      res     <= '0;
      res_vld <= 1'b0;
`ifndef SEQ_MULTIPLIER_EARLY_TERM_EN
      cnt     <= '0;
`endif
    end else begin
      // Operands are captured only on the accept edge (IDLE or DONE only).
      if (accept) begin
        mcand  <= PW'(abs_a);
        mplier <= abs_b;
        acc    <= '0;
        neg    <= op_neg;
`ifndef SEQ_MULTIPLIER_EARLY_TERM_EN
        cnt    <= '0;
`endif
      end

      case (state)
        IDLE: begin
          if (accept) begin
            state <= BUSY;
          end
        end
        BUSY: begin
          acc    <= acc_step;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
`ifndef SEQ_MULTIPLIER_EARLY_TERM_EN
          cnt    <= cnt + CNT_W'(1);
`endif
          if (last_step) begin
            state <= FIN;
          end
        end
        FIN: begin
          res     <= neg ? (-acc) : acc;
          res_vld <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          if (res_rdy) begin
            res_vld <= 1'b0;
            state   <= accept ? BUSY : IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier (WIDTH=8): directed vector table,
// backpressure / same-edge pop+accept, mid-operation reset, and a signed and
// unsigned random sweep against a behavioural product.
module tb_seq_multiplier;

  localparam int unsigned W = 8;

  logic          clk;
  logic          rst;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          in_signed;
  logic          in_vld;
  logic          in_rdy;
  logic [2*W-1:0] res;
  logic          res_vld;
  logic          res_rdy;

  int checks = 0;
  int errors = 0;

  seq_multiplier #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_signed (in_signed),
    .in_vld    (in_vld),
    .in_rdy    (in_rdy),
    .res       (res),
    .res_vld   (res_vld),
    .res_rdy   (res_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           s;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Edges from accept to res_vld rise, counting the accept edge itself.
  function automatic int exp_lat(input logic [W-1:0] b, input logic s);
`ifdef SEQ_MULTIPLIER_EARLY_TERM_EN
    logic [W-1:0] m;
    int           steps;
    m     = (s && b[W-1]) ? (~b + W'(1)) : b;
    steps = 1;
    for (int i = 0; i < int'(W); i++) begin
      if (m[i]) steps = i + 1;
    end
    return steps + 2;
`else
    return int'(W) + 2;
`endif
  endfunction

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
    logic [2*W-1:0] xa;
    logic [2*W-1:0] xb;
    xa = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    xb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return xa * xb;
  endfunction

  // Called just after the accept edge; waits for res_vld and checks latency.
  task automatic wait_res(input string name, input int lat);
    int n;
    n = 1;
    while (!res_vld && n < 64) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, "_vld"}, 32'(res_vld), 32'd1);
    chk({name, "_lat"}, 32'(n), 32'(lat));
  endtask

  task automatic pop(input string name);
    res_rdy = 1'b1;
    @(posedge clk);
    #1;
    res_rdy = 1'b0;
    chk({name, "_pop"}, 32'(res_vld), 32'd0);
  endtask

  // Issue one operation from IDLE, scramble the operand ports afterwards, check result.
  task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input logic [2*W-1:0] exp);
    in_a      = a;
    in_b      = b;
    in_signed = s;
    in_vld    = 1'b1;
    chk({name, "_rdy"}, 32'(in_rdy), 32'd1);
    @(posedge clk);
    #1;
    in_vld    = 1'b0;
    in_a      = ~a;
    in_b      = ~b;
    in_signed = ~s;
    wait_res(name, exp_lat(b, s));
    chk({name, "_res"}, 32'(res), 32'(exp));
    pop(name);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rs;

    vecs[0]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    vecs[1]  = '{8'hFD, 8'h05, 1'b1, 16'hFFF1};
    vecs[2]  = '{8'h80, 8'h80, 1'b1, 16'h4000};
    vecs[3]  = '{8'h7F, 8'h80, 1'b1, 16'hC080};
    vecs[4]  = '{8'hFD, 8'h05, 1'b0, 16'h04F1};
    vecs[5]  = '{8'h00, 8'h85, 1'b1, 16'h0000};
    vecs[6]  = '{8'h00, 8'hFF, 1'b0, 16'h0000};
    vecs[7]  = '{8'h85, 8'h00, 1'b1, 16'h0000};
    vecs[8]  = '{8'h12, 8'h34, 1'b0, 16'h03A8};
    vecs[9]  = '{8'hFF, 8'h01, 1'b1, 16'hFFFF};
    vecs[10] = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
    vecs[11] = '{8'h80, 8'h7F, 1'b0, 16'h3F80};
    vecs[12] = '{8'h80, 8'hFF, 1'b1, 16'h0080};

    rst       = 1'b1;
    in_a      = '0;
    in_b      = '0;
    in_signed = 1'b0;
    in_vld    = 1'b0;
    res_rdy   = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_res", 32'(res), 32'd0);
    chk("rst_vld", 32'(res_vld), 32'd0);
    chk("rst_rdy", 32'(in_rdy), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_rdy", 32'(in_rdy), 32'd1);

    // Directed vector table
    for (int i = 0; i < 13; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp);
    end

    // Backpressure, then pop and accept on the same edge
    in_a      = 8'h05;
    in_b      = 8'h06;
    in_signed = 1'b0;
    in_vld    = 1'b1;
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    chk("bp_busy_rdy", 32'(in_rdy), 32'd0);
    wait_res("bp", exp_lat(8'h06, 1'b0));
    chk("bp_res", 32'(res), 32'h1E);
    in_a   = 8'h03;
    in_b   = 8'h04;
    in_vld = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp_hold%0d", c), {15'd0, res, res_vld, in_rdy}, {15'd0, 16'h001E, 1'b1, 1'b0});
    end
    res_rdy = 1'b1;
    #1;
    chk("bp_pop_rdy", 32'(in_rdy), 32'd1);
    @(posedge clk);
    #1;
    res_rdy = 1'b0;
    in_vld  = 1'b0;
    in_a    = 8'hAA;
    in_b    = 8'h55;
    chk("bp_pop_vld", 32'(res_vld), 32'd0);
    chk("bp_next_busy", 32'(in_rdy), 32'd0);
    wait_res("bp_next", exp_lat(8'h04, 1'b0));
    chk("bp_next_res", 32'(res), 32'h000C);
    pop("bp_next");

    // Reset in the middle of BUSY clears outputs without a clock edge
    in_a      = 8'h0F;
    in_b      = 8'h0F;
    in_signed = 1'b0;
    in_vld    = 1'b1;
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_res", 32'(res), 32'd0);
    chk("mid_rst_vld", 32'(res_vld), 32'd0);
    chk("mid_rst_rdy", 32'(in_rdy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_idle_rdy", 32'(in_rdy), 32'd1);
    do_op("after_rst", 8'h12, 8'h34, 1'b0, 16'h03A8);

    // Random signed/unsigned sweep
    for (int k = 0; k < 300; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom_range(0, 1));
      do_op($sformatf("rnd%0d", k), ra, rb, rs, model(ra, rb, rs));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
